// File: rtl/dz_count_ctrl.sv
// Countdown controller: debounced start/pause and clear buttons drive an
// IDLE/RUN/PAUSE/DONE machine that steps num down once every TICK_DIV cycles.
module dz_count_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int START_VAL = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clr,
    output logic [2:0] num,
    output logic       running,
    output logic       done
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam int            CW        = $clog2(DB_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_0   = {PW{1'b0}};
    localparam logic [CW-1:0] DB_MAX    = CW'(DB_CYCLES - 1);
    localparam logic [2:0]    NUM_LOAD  = 3'(START_VAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Button paths: bit 0 is start, bit 1 is clear.
    logic [1:0]          meta_d, meta_q;
    logic [1:0]          sync_d, sync_q;
    logic [1:0]          level_d, level_q;
    logic [1:0]          evt_d, evt_q;
    logic [1:0][CW-1:0]  cnt_d, cnt_q;

    state_t              state_d, state_q;
    logic [2:0]          num_d, num_q;
    logic [PW-1:0]       presc_d, presc_q;
    logic                running_d, running_q;
    logic                done_d, done_q;

    logic                start_evt_s;
    logic                clr_evt_s;
    logic                tick_s;

    assign start_evt_s = evt_q[0];
    assign clr_evt_s   = evt_q[1];
    assign tick_s      = (presc_q == PRESC_MAX);

    assign num     = num_q;
    assign running = running_q;
    assign done    = done_q;

    // Synchronizer and debounce next-state; a press event fires only on an accepted rising level.
    always_comb begin
        meta_d  = {btn_clr, btn_start};
        sync_d  = meta_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        evt_d   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    level_d[i] = sync_q[i];
                    cnt_d[i]   = {CW{1'b0}};
                    evt_d[i]   = sync_q[i];
                end else begin
                    level_d[i] = level_q[i];
                    cnt_d[i]   = cnt_q[i] + CW'(1);
                    evt_d[i]   = 1'b0;
                end
            end else begin
                level_d[i] = level_q[i];
                cnt_d[i]   = {CW{1'b0}};
                evt_d[i]   = 1'b0;
            end
        end
    end

    // Button synchronizer and debounce registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 2'b00;
            sync_q  <= 2'b00;
            level_q <= 2'b00;
            cnt_q   <= {(2*CW){1'b0}};
            evt_q   <= 2'b00;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    // Countdown FSM next-state; clear outranks every other event.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        presc_d = presc_q;
        if (clr_evt_s) begin
            state_d = S_IDLE;
            num_d   = NUM_LOAD;
            presc_d = PRESC_0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    num_d   = NUM_LOAD;
                    presc_d = PRESC_0;
                    if (start_evt_s) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (tick_s) begin
                        // The step lands even when a pause arrives on the same edge.
                        presc_d = PRESC_0;
                        if (num_q <= 3'd1) begin
                            num_d   = 3'd0;
                            state_d = S_DONE;
                        end else begin
                            num_d   = num_q - 3'd1;
                            state_d = start_evt_s ? S_PAUSE : S_RUN;
                        end
                    end else if (start_evt_s) begin
                        state_d = S_PAUSE;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (start_evt_s) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                S_DONE: begin
                    if (start_evt_s) begin
                        state_d = S_IDLE;
                        num_d   = NUM_LOAD;
                        presc_d = PRESC_0;
                    end else begin
                        state_d = S_DONE;
                        num_d   = 3'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    num_d   = NUM_LOAD;
                    presc_d = PRESC_0;
                end
            endcase
        end
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    // Countdown FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            num_q     <= NUM_LOAD;
            presc_q   <= PRESC_0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_dz_count_ctrl.sv
// Scoreboard bench for dz_count_ctrl: stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares them against num/running/done.
module tb_dz_count_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;
    localparam int START_VAL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clr = 1'b0;
    logic [2:0] num;
    logic       running;
    logic       done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        int cyc;
        int num;
        int run;
        int dn;
    } exp_t;

    exp_t sb[$];

    dz_count_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DB_CYCLES(DB_CYCLES),
        .START_VAL(START_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .btn_clr  (btn_clr),
        .num      (num),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Cycle stamp: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_span(input int c0, input int c1, input int n, input int r, input int d);
        exp_t e;
        for (int c = c0; c <= c1; c++) begin
            e.cyc = c;
            e.num = n;
            e.run = r;
            e.dn  = d;
            sb.push_back(e);
        end
    endtask

    // Countdown that would start at n0 with a fresh prescaler at cycle r0; pushes cycles c0..c1.
    task automatic expect_countdown(input int r0, input int n0, input int c0, input int c1);
        exp_t e;
        int   v;
        for (int c = c0; c <= c1; c++) begin
            v = n0 - (c - r0) / TICK_DIV;
            e.cyc = c;
            if (v <= 0) begin
                e.num = 0;
                e.run = 0;
                e.dn  = 1;
            end else begin
                e.num = v;
                e.run = 1;
                e.dn  = 0;
            end
            sb.push_back(e);
        end
    endtask

    task automatic press(input bit s, input bit c, input int h);
        if (s) btn_start = 1'b1;
        if (c) btn_clr = 1'b1;
        repeat (h) @(negedge clk);
        btn_start = 1'b0;
        btn_clr   = 1'b0;
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            if (sb[0].cyc < cyc) begin
                check($sformatf("late@%0d", sb[0].cyc), cyc, sb[0].cyc);
            end else begin
                check($sformatf("num@%0d", cyc), num, sb[0].num);
                check($sformatf("running@%0d", cyc), running, sb[0].run);
                check($sformatf("done@%0d", cyc), done, sb[0].dn);
            end
            sb.delete(0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, r, s, t;

        repeat (3) @(negedge clk);
        check("rst_num", num, 5);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Two-cycle bounce: no event, stays idle.
        b = cyc;
        expect_span(b + 1, b + 12, 5, 0, 0);
        press(1'b1, 1'b0, 2);
        repeat (12) @(negedge clk);

        // Clean press: run, 5..0 every 4 cycles, then hold in DONE.
        b = cyc;
        expect_span(b + 1, b + 5, 5, 0, 0);
        expect_countdown(b + 6, 5, b + 6, b + 34);
        press(1'b1, 1'b0, 5);
        repeat (29) @(negedge clk);

        // DONE -> IDLE on start.
        b = cyc;
        expect_span(b + 1, b + 5, 0, 0, 1);
        expect_span(b + 6, b + 10, 5, 0, 0);
        press(1'b1, 1'b0, 5);
        repeat (6) @(negedge clk);

        // Second press -> RUN; pause at num=3 with prescaler at 2, resume 20 cycles later.
        b = cyc;
        r = b + 6;
        expect_span(b + 1, b + 5, 5, 0, 0);
        expect_countdown(r, 5, r, r + 10);
        expect_span(r + 11, r + 30, 3, 0, 0);
        expect_countdown(r + 29, 3, r + 31, r + 45);
        press(1'b1, 1'b0, 5);
        repeat (6) @(negedge clk);
        press(1'b1, 1'b0, 5);
        repeat (15) @(negedge clk);
        press(1'b1, 1'b0, 5);
        repeat (15) @(negedge clk);

        // Clear from DONE, then start and clear together at num=2.
        b = cyc;
        expect_span(b + 1, b + 5, 0, 0, 1);
        expect_span(b + 6, b + 10, 5, 0, 0);
        press(1'b0, 1'b1, 5);
        repeat (6) @(negedge clk);
        b = cyc;
        s = b + 6;
        expect_span(b + 1, b + 5, 5, 0, 0);
        expect_countdown(s, 5, s, s + 12);
        expect_span(s + 13, s + 22, 5, 0, 0);
        press(1'b1, 1'b0, 5);
        repeat (8) @(negedge clk);
        press(1'b1, 1'b1, 5);
        repeat (10) @(negedge clk);

        // Reset mid-RUN at num=3 takes effect without a clock edge.
        b = cyc;
        t = b + 6;
        expect_span(b + 1, b + 5, 5, 0, 0);
        expect_countdown(t, 5, t, t + 9);
        press(1'b1, 1'b0, 5);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_num", num, 5);
        check("async_rst_running", running, 0);
        check("async_rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        b = cyc;
        expect_span(b + 1, b + 12, 5, 0, 0);
        repeat (12) @(negedge clk);

        // Button held through reset release needs a full debounce first.
        #2 rst = 1'b1;
        btn_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        b = cyc;
        expect_span(b + 1, b + 5, 5, 0, 0);
        expect_countdown(b + 6, 5, b + 6, b + 12);
        repeat (8) @(negedge clk);
        btn_start = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dz_count_ctrl.md
DZ_COUNT_CTRL -- requirements
Module: dz_count_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clk cycles per countdown step (>=2).
REQ-002 SHALL have parameter DB_CYCLES, default 1_000_000, consecutive stable cycles required to accept a button level change (>=2).
REQ-003 SHALL have parameter START_VAL, default 5, countdown load value (1..7).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 btn_start  input  1  raw start/pause button, active-high, asynchronous to clk, may bounce.
REQ-007 btn_clr  input  1  raw clear button, active-high, asynchronous to clk, may bounce.
REQ-008 num  output  3  current count value, drives the dot-matrix display stage's num input.
REQ-009 running  output  1  high while in RUN.
REQ-010 done  output  1  high while in DONE.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Debounce per button: the debounced level SHALL change only after the synced input has differed from it for DB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-013 A press event SHALL be a one-cycle pulse on the cycle after the debounced level rises; release SHALL generate no event.
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSE, DONE, and SHALL act on a press event at the next clock edge.
REQ-015 IDLE: num=START_VAL, prescaler=0; start event -> RUN.
REQ-016 RUN: prescaler counts 0..TICK_DIV-1 and wraps; tick asserted when prescaler==TICK_DIV-1.
REQ-017 RUN: on tick, num SHALL decrement by 1 on that same edge; if num==1 at tick, num->0 and state->DONE.
REQ-018 RUN: start event -> PAUSE; prescaler and num SHALL hold their values.
REQ-019 PAUSE: start event -> RUN; prescaler SHALL resume from the held value, not from 0.
REQ-020 DONE: num held at 0; start event -> IDLE (num reloads START_VAL).
REQ-021 Clear event in any state SHALL force IDLE, num=START_VAL, prescaler=0; clear SHALL take priority over a simultaneous start event.
REQ-022 Tick and start event in the same RUN cycle: decrement SHALL apply and state->PAUSE, except that reaching 0 SHALL go to DONE instead.
REQ-023 num SHALL never underflow below 0 and never exceed START_VAL.
REQ-024 Prescaler SHALL be sized $clog2(TICK_DIV) bits and SHALL not advance outside RUN.
REQ-025 All outputs SHALL be registered; running and done SHALL be mutually exclusive.

Reset
REQ-026 On rst high, asynchronously: state=IDLE, num=START_VAL, prescaler=0, running=0, done=0, synchronizers, debounced levels, and debounce counters=0.
REQ-027 Reset asserted mid-RUN or mid-PAUSE SHALL discard all count progress; after release the block SHALL wait in IDLE for a new start event.
REQ-028 A button held through reset release SHALL produce a press event only after DB_CYCLES stable cycles, never immediately.

Verification (TICK_DIV=4, DB_CYCLES=3, START_VAL=5)
REQ-029 btn_start high for 2 cycles then low (bounce) -> no event, state stays IDLE, num=5.
REQ-030 clean btn_start press -> running=1 within DB_CYCLES+4 cycles; num steps 5,4,3,2,1,0 every 4 cycles; on reaching 0: running=0, done=1, num holds at 0.
REQ-031 press start in RUN after 2 prescaler cycles at num=3, wait 20 cycles, press again -> num stays 3 during PAUSE; first decrement to 2 occurs 2 cycles after resume.
REQ-032 btn_start and btn_clr pressed simultaneously in RUN at num=2 -> IDLE, num=5, running=0.
REQ-033 rst pulsed mid-RUN at num=3 -> num=5, running=0, done=0 immediately, without waiting for a clock edge.
REQ-034 in DONE press start -> IDLE, num=5, done=0; second press -> RUN.
